// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order writeback stage and buffered multiply/divide results. MD results
// wait in a small FIFO, drain in idle pipeline cycles, and are forced through
// by holding the pipeline on starvation or a write-after-write conflict.
module wb_port_arbiter #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        PIPE_WB_VALID,
   input  logic [4:0]  PIPE_WB_RD,
   input  logic [31:0] PIPE_WB_DATA,
   input  logic        MD_VALID,
   output logic        MD_READY,
   input  logic [4:0]  MD_RD,
   input  logic [31:0] MD_DATA,
   output logic        PIPE_HOLD,
   output logic [31:0] RD_PENDING,
   output logic        RF_WE,
   output logic [4:0]  RF_WADDR,
   output logic [31:0] RF_WDATA
);

   localparam int              PW        = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]     DEPTH_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [7:0]      LIMIT     = 8'(STARVE_LIMIT);

   // FIFO payload and pointers; the extra pointer bit separates full from empty
   logic [4:0]    fifo_rd   [FIFO_DEPTH];
   logic [31:0]   fifo_data [FIFO_DEPTH];
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [PW:0]   count;
   logic [PW-1:0] slot_off;
   logic [7:0]    starve_cnt;

   logic          empty;
   logic          full;
   logic          md_ready_int;
   logic          push;
   logic          pop;
   logic          waw_hold;
   logic          starve_hold;
   logic          hold;
   logic          pipe_win;
   logic [31:0]   pending;

   logic          rf_we_q;
   logic [4:0]    rf_waddr_q;
   logic [31:0]   rf_wdata_q;

   assign count        = wr_ptr - rd_ptr;
   assign empty        = (count == '0);
   assign full         = (count == DEPTH_CNT);
   assign md_ready_int = !full && !RST;
   assign push         = MD_VALID && md_ready_int;

   // A pipeline write to a buffered rd must wait until the older MD write retires
   assign waw_hold     = PIPE_WB_VALID && (PIPE_WB_RD != 5'd0) && pending[PIPE_WB_RD];
   assign starve_hold  = (starve_cnt == LIMIT) && !empty;
   assign hold         = !RST && (waw_hold || starve_hold);
   assign pipe_win     = PIPE_WB_VALID && !hold;
   assign pop          = !RST && !pipe_win && !empty;

   // Pending-destination mask built from the occupied FIFO slots
   always_comb begin
      // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
      pending  = '0;
      slot_off = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         slot_off = PW'(i) - rd_ptr[PW-1:0];
         if ({1'b0, slot_off} < count) pending[fifo_rd[i]] = 1'b1;
      end
      pending[0] = 1'b0;
   end

   // FIFO payload write at the tail
   always_ff @(posedge CLK) begin
      // NOTE: payload words are not reset; occupancy lives in the pointers, so stale words are never seen.
      if (push) begin
         fifo_rd[wr_ptr[PW-1:0]]   <= MD_RD;
         fifo_data[wr_ptr[PW-1:0]] <= MD_DATA;
      end
   end

   // Pointers, starvation counter and the registered write-port drive
   always_ff @(posedge CLK) begin
      // NOTE: state uses <= so every flop samples pre-edge values independent of statement order.
      if (RST) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         starve_cnt <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         if (pop || empty)          starve_cnt <= '0;
         else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;

         if (pipe_win) begin
            rf_we_q    <= (PIPE_WB_RD != 5'd0);
            rf_waddr_q <= PIPE_WB_RD;
            rf_wdata_q <= PIPE_WB_DATA;
         end else if (pop) begin
            rf_we_q    <= (fifo_rd[rd_ptr[PW-1:0]] != 5'd0);
            rf_waddr_q <= fifo_rd[rd_ptr[PW-1:0]];
            rf_wdata_q <= fifo_data[rd_ptr[PW-1:0]];
         end else begin
            rf_we_q    <= 1'b0;
         end
      end
   end

   // Outputs read as their reset values for the whole time reset is high
   assign MD_READY   = md_ready_int;
   assign PIPE_HOLD  = hold;
   assign RD_PENDING = RST ? 32'd0 : pending;
   assign RF_WE      = rf_we_q && !RST;
   assign RF_WADDR   = RST ? 5'd0  : rf_waddr_q;
   assign RF_WDATA   = RST ? 32'd0 : rf_wdata_q;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and the out-of-order multi-cycle multiply/divide (MD) unit. MD results are buffered in a small FIFO, drained in cycles where the pipeline does not write, and forced through by holding the pipeline when they starve or when a write-after-write (WAW) conflict appears. A pending-destination mask feeds the register state scoreboard, so readers of a buffered rd stall until the write retires.

## Interface
- FIFO_DEPTH, 2, MD result buffer entries; power of two, 2..8
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO head waits before a forced drain; 1..255
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- PIPE_WB_VALID  in  1  pipeline writeback request this cycle
- PIPE_WB_RD  in  5  pipeline destination register
- PIPE_WB_DATA  in  32  pipeline write data
- MD_VALID  in  1  MD result valid
- MD_READY  out  1  arbiter can accept an MD result
- MD_RD  in  5  MD destination register
- MD_DATA  in  32  MD result
- PIPE_HOLD  out  1  pipeline must hold its writeback stage; request is re-presented next cycle
- RD_PENDING  out  32  bit i set while an MD write to xi is buffered; bit 0 always 0
- RF_WE  out  1  register-file write enable
- RF_WADDR  out  5  register-file write address
- RF_WDATA  out  32  register-file write data

## Operation
- MD push: on MD_VALID & MD_READY, {MD_RD, MD_DATA} is appended at the FIFO tail. MD_READY = !full & !RST.
- Write sources, in priority order:
  - Pipeline wins when PIPE_WB_VALID & !PIPE_HOLD.
  - Otherwise the FIFO head is popped and written if the FIFO is non-empty.
  - Otherwise no write occurs.
- PIPE_HOLD = starve_hold | waw_hold. Both terms are combinational from registered state and current inputs.
  - waw_hold: PIPE_WB_VALID & PIPE_WB_RD != 0 & RD_PENDING[PIPE_WB_RD].
  - starve_hold: starve_cnt == STARVE_LIMIT & FIFO non-empty.
- The older MD write always retires before a younger pipeline write to the same rd.
- starve_cnt (8 bit):
  - Clears on reset, on any pop, and whenever the FIFO is empty.
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Saturates at STARVE_LIMIT.
- Writes with rd == 0 are consumed normally (popped or accepted) but produce RF_WE = 0.
- RD_PENDING is the OR of the one-hot decodes of the rd fields of valid FIFO entries. It is updated from registered FIFO state, so it reflects a push in the cycle after the push.
- Simultaneous push and pop on a full FIFO: MD_READY is already 0, so no push occurs. Simultaneous push and pop on a non-full FIFO: both take effect, and the count is unchanged.
- A pipeline FLUSH does not affect this block; buffered MD results belong to committed instructions and always retire.

## Timing
- Reset values: RF_WE = 0, RF_WADDR = 0, RF_WDATA = 0, RD_PENDING = 0, PIPE_HOLD = 0, MD_READY = 0 while RST is high. FIFO is empty and starve_cnt = 0.
- Reset asserted mid-operation discards all buffered entries. No write occurs in the cycles following reset.
- RF_WE/RF_WADDR/RF_WDATA are registered: a source selected in cycle N is driven in cycle N+1 for exactly one cycle.
- Minimum MD latency: push in N, pop in N+1, RF_WE in N+2. The FIFO has no bypass path.
- Pipeline writeback latency: request in N, RF_WE in N+1.
- PIPE_HOLD lasts exactly one cycle for a starvation drain. For WAW it lasts until the conflicting entry pops: hold in the pop cycle, released the cycle after.
- FIFO pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses an extra pointer bit or a count register.

## Test plan
- Reset mid-stream: fill FIFO with 2 entries, pulse RST one cycle -> RD_PENDING = 0, MD_READY = 1 after release, no RF_WE for the discarded entries.
- Idle pipeline, MD push rd=5/0xDEADBEEF at cycle 0 -> RD_PENDING[5] = 1 at cycle 1, RF_WE = 1 with RF_WADDR = 5 and RF_WDATA = 0xDEADBEEF at cycle 2, RD_PENDING = 0 at cycle 2.
- Pipeline writes every cycle, one MD entry rd=7 buffered, STARVE_LIMIT = 8 -> PIPE_HOLD = 1 exactly on the 9th waiting cycle, rd 7 written next cycle, pipeline write re-presented and written the cycle after.
- MD push rd=3, next cycle pipeline presents rd=3 while the pipeline is otherwise busy -> PIPE_HOLD held until the MD rd=3 pops; RF writes to x3 occur in order MD then pipeline.
- Three back-to-back MD pushes, FIFO_DEPTH = 2, pipeline busy -> MD_READY = 0 after the second push, the third push is accepted only after the first pop, and all three are written in push order.
- MD push with rd=0 and pipeline write to rd=0 -> both consumed, RF_WE stays 0, RD_PENDING[0] stays 0.
